// File: rtl/cadd_share_arb_pkg.sv
// Shared FFT datapath package: default component width, result-register
// state type and helpers for the packed complex word {re, im}.
package cadd_share_arb_pkg;

  localparam int W_DEF  = 11;
  localparam int CW_DEF = 2 * W_DEF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

  // Bit offset of the real field inside a packed complex word of component width w
  function automatic int re_lsb(input int w);
    return w;
  endfunction

  // Bit offset of the imaginary field inside a packed complex word
  function automatic int im_lsb(input int w);
    return 0 * w;
  endfunction

  // Signed overflow of a wrapped two-operand sum, from the three sign bits
  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/cadd_share_arb_if.sv
// Requester/consumer bus of the shared complex adder.
// master = requesters + result consumer, slave = the arbiter block.
interface cadd_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 11,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*2*W-1:0]   req_a;
  logic [NREQ*2*W-1:0]   req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*W-1:0]        res_y;
  logic [IDW-1:0]        res_id;
  logic [1:0]            res_ovf;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_y, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_y, res_id, res_ovf
  );
endinterface

// File: rtl/cadd_share_arb_cadd.sv
// Combinational complex adder: per-component W-bit two's-complement wrap.
module cadd #(
  parameter int W = 11
) (
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic [2*W-1:0] y
);
  logic signed [W-1:0] a_re, a_im, b_re, b_im, y_re, y_im;

  // Split the packed operands and add each component with wrap-around
  always_comb begin
    a_re = a[2*W-1:W];
    a_im = a[W-1:0];
    b_re = b[2*W-1:W];
    b_im = b[W-1:0];
    y_re = a_re + b_re;
    y_im = a_im + b_im;
    y    = {y_re, y_im};
  end
endmodule

// File: rtl/cadd_share_arb_rr_arbiter.sv
// Round-robin grant logic: first requester at or after ptr wins.
// The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  int   j;
  logic found;

  // Scan ptr, ptr+1, ... modulo NREQ and one-hot the first active request
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    if (en && found) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/cadd_share_arb.sv
// Time-shares one complex adder between NREQ requesters; the registered
// result (sum, winner index, overflow flags) is held until consumed.
module cadd_share_arb
  import cadd_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  cadd_share_arb_if.slave    bus
);
  localparam int RE_MSB = re_lsb(W) + W - 1;
  localparam int IM_MSB = im_lsb(W) + W - 1;

  res_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   win_idx;
  logic [NREQ-1:0]  gnt;
  logic             can_accept;
  logic             accept;
  logic [2*W-1:0]   a_p0, b_p0, sum_p0;
  logic [1:0]       ovf_p0;
  logic [2*W-1:0]   y_p1;
  logic [IDW-1:0]   id_p1;
  logic [1:0]       ovf_p1;

  assign can_accept = rst_n && ((state_q == EMPTY) || bus.res_ready);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (can_accept),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  // Stage p0: winner operand mux, shared adder, sign-based overflow
  assign a_p0 = bus.req_a[int'(win_idx)*(2*W) +: 2*W];
  assign b_p0 = bus.req_b[int'(win_idx)*(2*W) +: 2*W];

  cadd #(.W(W)) u_add (
    .a (a_p0),
    .b (b_p0),
    .y (sum_p0)
  );

  assign ovf_p0 = {add_ovf(a_p0[RE_MSB], b_p0[RE_MSB], sum_p0[RE_MSB]),
                   add_ovf(a_p0[IM_MSB], b_p0[IM_MSB], sum_p0[IM_MSB])};

  // Next result-register state and round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = FULL;
      ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end else if ((state_q == FULL) && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  // Control state: FSM and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Stage p1: result register, loaded only on accept, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1   <= '0;
      id_p1  <= '0;
      ovf_p1 <= '0;
    end else if (accept) begin
      y_p1   <= sum_p0;
      id_p1  <= win_idx;
      ovf_p1 <= ovf_p0;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_y     = y_p1;
  assign bus.res_id    = id_p1;
  assign bus.res_ovf   = ovf_p1;
endmodule

// File: tb/tb_cadd_share_arb.sv
// Bench for cadd_share_arb: table-driven arbitration sequence, hand-written
// arithmetic/reset sequences and a randomized run against a reference model.
module tb_cadd_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 11;
  localparam int IDW  = 2;
  localparam int CW   = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cadd_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  cadd_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int a_re[NREQ], a_im[NREQ], b_re[NREQ], b_im[NREQ];

  // reference model state
  logic          m_valid;
  logic [CW-1:0] m_y;
  int            m_id;
  logic [1:0]    m_ovf;
  int            m_ptr;

  typedef struct {
    logic [NREQ-1:0] v;
    logic            rr;
    logic [NREQ-1:0] er;
    logic            ev;
    logic [IDW-1:0]  eid;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack(input int re, input int im);
    logic [W-1:0] r, i;
    r = re[W-1:0];
    i = im[W-1:0];
    return {r, i};
  endfunction

  function automatic int wrap(input int s);
    int r;
    r = s & 2047;
    if (r >= 1024) r = r - 2048;
    return r;
  endfunction

  function automatic vec_t mk(input logic [NREQ-1:0] v, input logic rr,
                              input logic [NREQ-1:0] er, input logic ev,
                              input logic [IDW-1:0] eid);
    vec_t t;
    t.v = v; t.rr = rr; t.er = er; t.ev = ev; t.eid = eid;
    return t;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*CW +: CW] = pack(a_re[i], a_im[i]);
      bus.req_b[i*CW +: CW] = pack(b_re[i], b_im[i]);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_y = '0; m_id = 0; m_ovf = 2'b00; m_ptr = 0;
  endtask

  // One clock of the specified behaviour: returns the expected grant vector
  // and advances the model as if the edge had happened.
  task automatic model_step(input logic [NREQ-1:0] v, input logic rr,
                            output logic [NREQ-1:0] exp_rdy);
    int w, sre, sim;
    w = -1;
    exp_rdy = '0;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    if ((!m_valid || rr) && w >= 0) begin
      exp_rdy[w] = 1'b1;
      sre = a_re[w] + b_re[w];
      sim = a_im[w] + b_im[w];
      m_y   = pack(wrap(sre), wrap(sim));
      m_ovf = {(sre > 1023 || sre < -1024), (sim > 1023 || sim < -1024)};
      m_id  = w;
      m_valid = 1'b1;
      m_ptr = (w + 1) % NREQ;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic int rnd_comp();
    case ($urandom_range(0, 5))
      0: return 1023;
      1: return -1024;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  initial begin
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] er;
    logic            rr;

    bus.req_valid = '1;
    bus.res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_re[i] = 10 * i + 1; a_im[i] = -i; b_re[i] = i; b_im[i] = 2;
    end
    drive_ops();

    // table: round-robin, backpressure, drain+accept, sparse requests, ptr=2
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, IDW'(i % 4));
    for (int i = 8; i < 13; i++)
      tbl[i] = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    tbl[13] = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    tbl[14] = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3);
    tbl[15] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    tbl[16] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);
    tbl[17] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1);
    tbl[18] = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);

    // reset state with requests pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_y", bus.res_y, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_ovf", bus.res_ovf, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      bus.req_valid = tbl[i].v;
      bus.res_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), bus.req_ready, tbl[i].er);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_res_valid", i), bus.res_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_res_id", i), bus.res_id, tbl[i].eid);
    end

    // single add from requester 2 (ptr=3, so scan wraps to reach 2)
    a_re[2] = 3; a_im[2] = -5; b_re[2] = 4; b_im[2] = 7;
    drive_ops();
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    #1;
    chk("add_req_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("add_res_valid", bus.res_valid, 1);
    chk("add_res_y", bus.res_y, pack(7, 2));
    chk("add_res_id", bus.res_id, 2);
    chk("add_res_ovf", bus.res_ovf, 2'b00);

    // wrap-around overflow in both components
    a_re[2] = 1023; a_im[2] = -1024; b_re[2] = 1; b_im[2] = -1;
    drive_ops();
    #1;
    chk("ovf_req_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("ovf_res_y", bus.res_y, pack(-1024, 1023));
    chk("ovf_res_ovf", bus.res_ovf, 2'b11);

    // reset in the middle of a held transfer
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b0;
    #1;
    chk("mid_hold_req_ready", bus.req_ready, 4'b0000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_res_y", bus.res_y, 0);
    chk("mid_rst_res_id", bus.res_id, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    chk("post_rst_ptr0_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post_rst_res_id", bus.res_id, 0);

    // randomized run against the reference model, from a fresh reset
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    v = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && ($urandom_range(0, 1) == 1)) begin
          v[i] = 1'b1;
          a_re[i] = rnd_comp(); a_im[i] = rnd_comp();
          b_re[i] = rnd_comp(); b_im[i] = rnd_comp();
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      drive_ops();
      bus.req_valid = v;
      bus.res_ready = rr;
      #1;
      model_step(v, rr, er);
      chk("rand_req_ready", bus.req_ready, er);
      @(posedge clk); #1;
      chk("rand_res_valid", bus.res_valid, m_valid);
      chk("rand_res_y", bus.res_y, m_y);
      chk("rand_res_id", bus.res_id, m_id);
      chk("rand_res_ovf", bus.res_ovf, m_ovf);
      v = v & ~er;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/cadd_share_arb.md
# cadd_share_arb

Round-robin arbiter and result stage that time-shares one combinational complex adder between NREQ requesters in the FFT datapath (e.g. butterfly units, twiddle accumulators). Each requester presents a packed complex operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the packed sum together with the winner's index and per-component overflow flags, and holds the result until the consumer accepts it.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 11, signed width of each real/imag component; packed complex word = 2*W bits, {re, im}, re in upper half
- IDW, $clog2(NREQ), width of the requester index

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
- req_a  in  NREQ*2*W  operand A per requester, requester i at bits [i*2W +: 2W]
- req_b  in  NREQ*2*W  operand B, same packing
- res_valid  out  1  result register holds a valid sum
- res_ready  in  1  consumer accepts result
- res_y  out  2*W  packed sum {re, im}
- res_id  out  IDW  index of requester that produced res_y
- res_ovf  out  2  {re_ovf, im_ovf} signed overflow of the wrapped sum

## Operation
- Arithmetic: re = A.re + B.re, im = A.im + B.im, each W bits, two's-complement wrap-around (no saturation, no widening). ovf bit set when both operands share a sign and the wrapped sum's sign differs.
- Output register FSM, two states: EMPTY (res_valid=0), FULL (res_valid=1).
- can_accept = EMPTY, or FULL with res_ready=1 in the same cycle.
- Arbitration: round-robin pointer ptr (IDW bits). Winner = first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ. req_ready = one-hot(winner) when can_accept, else all-zero. req_ready depends combinationally on req_valid and res_ready; no other combinational input-to-output path.
- On accept (any req_ready bit high): load res_y, res_id, res_ovf from the winner; FSM -> FULL; ptr <- (winner+1) mod NREQ.
- FULL with res_ready=1 and no accept: FSM -> EMPTY; res_y/res_id/res_ovf hold their last values.
- No valid requests: ptr unchanged.
- Requesters must hold req_valid, req_a and req_b stable until accepted; the block never drops or reorders an accepted operation.
- Reset values: res_valid=0, res_y=0, res_id=0, res_ovf=2'b00, ptr=0, FSM=EMPTY. Reset mid-operation discards any pending result. req_ready is 0 while rst_n=0.

## Timing
- Latency: accept in cycle n -> res_valid=1 with that sum in cycle n+1.
- Throughput: one operation per cycle while res_ready stays high (simultaneous drain and accept in the same edge loads the new result; res_valid remains 1).
- Backpressure: res_ready=0 in FULL -> all req_ready=0; the result holds indefinitely.
- Fairness: with all NREQ requesters continuously valid and res_ready=1, grants rotate 0,1,...,NREQ-1,0,...; a waiting requester is granted within NREQ accepts.
- NREQ not a power of two: ptr wraps from NREQ-1 to 0 and never takes values >= NREQ.

## Structure
- Shared FFT package: W default, packed complex-word width 2*W, helpers/constants for re/im field slicing.
- Sub-module rr_arbiter (NREQ): inputs req vector, ptr, enable; outputs one-hot grant and encoded index. Pointer register stays in the top level.
- Adder: instantiate the existing combinational complex adder on the muxed winner operands; overflow detection is computed in this block from operand and sum signs.

## Test plan
- Reset: assert rst_n=0 mid-transfer with res_valid=1 -> res_valid=0, res_y=0, res_id=0, req_ready=0; after release, ptr=0.
- Single add: req 2 presents A={3,-5}, B={4,7}, res_ready=1 -> req_ready=4'b0100 in cycle n; cycle n+1 res_y={7,2}, res_id=2, res_ovf=00.
- Overflow wrap: A={1023,-1024}, B={1,-1} -> res_y={-1024,1023}, res_ovf=11.
- Round-robin: all 4 requesters valid, res_ready=1 for 8 cycles -> res_id sequence 0,1,2,3,0,1,2,3, with res_valid high every cycle from the first accept.
- Backpressure: res_ready=0 for 5 cycles while FULL -> req_ready=0 and res_y/res_id stable; raising res_ready -> drain and next accept happen in the same cycle.
- Sparse requests: only req 3 valid, then only req 1 -> grants 3, then 1; ptr becomes 0, then 2; no grant while no request is valid.
